aes_cmd_parser: RTL
===================

Name: aes_cmd_parser

Overview:
- Sits between the AXI-stream slave's 32-bit word output (wren/data/tlast, busy backpressure) and the AES controller's block input.
- Decodes the leading command word of each stream packet.
- Packs the following 32-bit words into 128-bit KEY, IV and DATA blocks and presents them one at a time over a valid/ready handshake.
- Detects malformed packets, drains them to tlast, and reports an error pulse.

Parameters:
- IN_BUS_WIDTH, 32: input word width; only 32 is supported.
- MAX_DATA_BLOCKS, 512: maximum 128-bit data blocks per packet.
- ECB_SUPPORT, 1: accept mode 0.
- CBC_SUPPORT, 1: accept mode 1.
- CTR_SUPPORT, 1: accept mode 2.
- CFB_SUPPORT, 1: accept mode 3.
- OFB_SUPPORT, 1: accept mode 4.
- PCBC_SUPPORT, 1: accept mode 5.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_bus_data_wren  in  1  word write strobe
- in_bus_data  in  32  word
- in_bus_tlast  in  1  last word of packet
- controller_in_busy  out  1  backpressure to slave; combinational, equals blk_valid
- cmd_valid  out  1  one-cycle pulse when the command word is accepted
- cmd_encrypt  out  1  1 = encrypt
- cmd_mode  out  3  chaining mode
- cmd_skip_key  out  1  key expansion reuses the previous key
- cmd_key256  out  1  256-bit key; always 0 when AES256_KEY_EN is undefined
- blk_valid  out  1  block available
- blk_ready  in  1  consumer accepts block
- blk_data  out  128  block; first word received in [127:96]
- blk_type  out  2  0 = KEY, 1 = IV, 2 = DATA
- blk_last  out  1  last DATA block of the packet
- err  out  1  one-cycle pulse when a malformed packet is detected

Behaviour:
- Reset values:
  - All outputs 0; state CMD; word_cnt 0; block_cnt 0.
  - Reset mid-packet discards everything: any held block is dropped and the remaining words are not drained. Upstream is reset by the same signal.
- Command word layout:
  - [0] encrypt.
  - [3:1] mode.
  - [4] skip_key.
  - [5] key256.
  - [31:6] ignored.
- Word acceptance:
  - A word is accepted only when in_bus_data_wren=1.
  - A write while controller_in_busy=1 is a protocol violation; that word is ignored and err pulses.
- Block assembly:
  - Words shift into a 128-bit assembly register; word_cnt is a 2-bit counter that wraps.
  - On the 4th word the block is copied to blk_data, blk_valid is set and word_cnt returns to 0.
  - blk_valid is set one cycle after the 4th write; latency is 1 clk.
- Output handshake:
  - blk_valid && blk_ready clears blk_valid on the next edge.
  - blk_data, blk_type and blk_last are held stable while blk_valid=1.
  - Back-to-back blocks are possible: upstream may write again in the cycle after the handshake.
- State machine:
  - CMD: on a write, latch the command fields and pulse cmd_valid.
    - Mode unsupported (per parameter, or mode>5) -> DRAIN, err pulse.
    - Otherwise skip_key=0 -> KEY.
    - Otherwise mode≠ECB -> IV.
    - Otherwise -> DATA.
    - tlast on the command word -> err, stay in CMD.
  - KEY: emit 1 KEY block (2 when key256=1, see Optional Feature), then IV if mode≠ECB, else DATA.
  - IV: emit 1 IV block, then DATA.
  - DATA: emit DATA blocks.
    - tlast on word_cnt==3 -> that block has blk_last=1, go to CMD.
    - tlast with word_cnt≠3 -> drop the partial block, err, go to CMD.
  - Any tlast in KEY or IV -> drop the partial block, err, go to CMD.
  - DATA block MAX_DATA_BLOCKS+1 completing without tlast -> err, block not emitted, go to DRAIN.
  - DRAIN: discard words until a write with tlast, then go to CMD. busy=0 while in DRAIN.
- block_cnt: clog2(MAX_DATA_BLOCKS+1) bits, reset on entry to DATA; it never wraps.
- Simultaneous events: a write and a blk handshake in the same cycle cannot occur, because busy=1 whenever blk_valid=1.

Optional Feature:
- Macro: AES256_KEY_EN.
- When defined:
  - cmd[5]=1 selects a 256-bit key.
  - KEY emits two KEY blocks: words 1–4 first, then words 5–8.
  - cmd_key256=1.
- When undefined:
  - cmd[5]=1 is treated as an unsupported command: err pulse, DRAIN.
  - cmd_key256 is tied to 0.

Test Plan:
- ECB encrypt:
  - Stimulus: cmd=0x00000001, key 0x00010203,0x04050607,0x08090A0B,0x0C0D0E0F, then 4 data words with tlast on the 4th.
  - Expected: cmd_valid with mode=0, encrypt=1; KEY block 0x000102030405060708090A0B0C0D0E0F type 0; one DATA block type 2 with blk_last=1.
- CBC skip-key:
  - Stimulus: cmd=0x00000012, 4 IV words, 8 data words.
  - Expected: no KEY block; IV block, then 2 DATA blocks, with blk_last only on the 2nd.
- Backpressure:
  - Stimulus: hold blk_ready=0 for 10 clks after a block completes.
  - Expected: busy=1 and blk_data stable throughout; a write injected while busy gives an err pulse and the block is unchanged.
- Truncation:
  - Stimulus: tlast on the 6th data word.
  - Expected: first DATA block emitted with blk_last=0; err pulse; the next cmd word is parsed normally.
- Unsupported mode:
  - Stimulus: CTR_SUPPORT=0, cmd=0x00000005, followed by 8 words with tlast.
  - Expected: err pulse; no blocks emitted; back in CMD afterwards.
- AES256_KEY_EN defined:
  - Stimulus: cmd=0x00000021, 8 key words.
  - Expected: two KEY blocks in arrival order, then DATA.
- AES256_KEY_EN undefined:
  - Stimulus: same cmd=0x00000021.
  - Expected: err pulse and DRAIN.

Source files
------------

// File: rtl/aes_cmd_parser.sv
// AES stream command parser: decodes the command word, packs 32-bit words into 128-bit KEY/IV/DATA blocks; 1 clk block latency.
// busy mirrors blk_valid so upstream stalls while a block is held; optional 256-bit keys via AES256_KEY_EN.
module aes_cmd_parser #(
  parameter int IN_BUS_WIDTH    = 32,
  parameter int MAX_DATA_BLOCKS = 512,
  parameter int ECB_SUPPORT     = 1,
  parameter int CBC_SUPPORT     = 1,
  parameter int CTR_SUPPORT     = 1,
  parameter int CFB_SUPPORT     = 1,
  parameter int OFB_SUPPORT     = 1,
  parameter int PCBC_SUPPORT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_bus_data_wren,
  input  logic [IN_BUS_WIDTH-1:0] in_bus_data,
  input  logic                    in_bus_tlast,
  output logic                    controller_in_busy,
  output logic                    cmd_valid,
  output logic                    cmd_encrypt,
  output logic [2:0]              cmd_mode,
  output logic                    cmd_skip_key,
  output logic                    cmd_key256,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [127:0]            blk_data,
  output logic [1:0]              blk_type,
  output logic                    blk_last,
  output logic                    err
);

  localparam int CNT_W = $clog2(MAX_DATA_BLOCKS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_BLOCKS);

  localparam logic [2:0] S_CMD   = 3'd0;
  localparam logic [2:0] S_KEY   = 3'd1;
  localparam logic [2:0] S_IV    = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [1:0] T_KEY  = 2'd0;
  localparam logic [1:0] T_IV   = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;

  logic [2:0]       state;
  logic [1:0]       word_cnt;
  logic [95:0]      asm_q;
  logic [CNT_W-1:0] block_cnt;
  logic             key_hi;
  logic             accept;
  logic             cmd_unsup;
  logic [127:0]     full_blk;

  function automatic logic mode_ok(input logic [2:0] m);
    case (m)
      3'd0:    mode_ok = (ECB_SUPPORT != 0);
      3'd1:    mode_ok = (CBC_SUPPORT != 0);
      3'd2:    mode_ok = (CTR_SUPPORT != 0);
      3'd3:    mode_ok = (CFB_SUPPORT != 0);
      3'd4:    mode_ok = (OFB_SUPPORT != 0);
      3'd5:    mode_ok = (PCBC_SUPPORT != 0);
      default: mode_ok = 1'b0;
    endcase
  endfunction

  assign controller_in_busy = blk_valid;
  assign accept   = in_bus_data_wren && !blk_valid;
  assign full_blk = {asm_q, in_bus_data};

`ifdef AES256_KEY_EN
  assign cmd_unsup = !mode_ok(in_bus_data[3:1]);
`else
  assign cmd_unsup = !mode_ok(in_bus_data[3:1]) || in_bus_data[5];
  assign cmd_key256 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_CMD;
      word_cnt     <= 2'd0;
      asm_q        <= '0;
      block_cnt    <= '0;
      key_hi       <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_encrypt  <= 1'b0;
      cmd_mode     <= 3'd0;
      cmd_skip_key <= 1'b0;
`ifdef AES256_KEY_EN
      cmd_key256   <= 1'b0;
`endif
      blk_valid    <= 1'b0;
      blk_data     <= '0;
      blk_type     <= 2'd0;
      blk_last     <= 1'b0;
      err          <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      if (blk_valid && blk_ready)
        blk_valid <= 1'b0;
      // A write while a block is held is dropped, not queued.
      if (in_bus_data_wren && blk_valid)
        err <= 1'b1;
      if (accept) begin
        case (state)
          S_CMD: begin
            cmd_valid    <= 1'b1;
            cmd_encrypt  <= in_bus_data[0];
            cmd_mode     <= in_bus_data[3:1];
            cmd_skip_key <= in_bus_data[4];
`ifdef AES256_KEY_EN
            cmd_key256   <= in_bus_data[5];
`endif
            word_cnt  <= 2'd0;
            key_hi    <= 1'b0;
            block_cnt <= '0;
            if (in_bus_tlast)
              err <= 1'b1;
            else if (cmd_unsup) begin
              err   <= 1'b1;
              state <= S_DRAIN;
            end else if (!in_bus_data[4])
              state <= S_KEY;
            else if (in_bus_data[3:1] != 3'd0)
              state <= S_IV;
            else
              state <= S_DATA;
          end
          S_DRAIN: begin
            if (in_bus_tlast)
              state <= S_CMD;
          end
          default: begin
            asm_q    <= {asm_q[63:0], in_bus_data};
            word_cnt <= word_cnt + 2'd1;
            if (in_bus_tlast && !(state == S_DATA && word_cnt == 2'd3)) begin
              err      <= 1'b1;
              word_cnt <= 2'd0;
              state    <= S_CMD;
            end else if (word_cnt == 2'd3) begin
              if (state == S_DATA && block_cnt == MAX_CNT) begin
                err   <= 1'b1;
                state <= in_bus_tlast ? S_CMD : S_DRAIN;
              end else begin
                blk_valid <= 1'b1;
                blk_data  <= full_blk;
                blk_last  <= 1'b0;
                case (state)
                  S_KEY: begin
                    blk_type <= T_KEY;
                    if (cmd_key256 && !key_hi)
                      key_hi <= 1'b1;
                    else
                      state <= (cmd_mode != 3'd0) ? S_IV : S_DATA;
                  end
                  S_IV: begin
                    blk_type <= T_IV;
                    state    <= S_DATA;
                  end
                  default: begin
                    blk_type  <= T_DATA;
                    blk_last  <= in_bus_tlast;
                    block_cnt <= block_cnt + 1'b1;
                    if (in_bus_tlast)
                      state <= S_CMD;
                  end
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule
